// File: rtl/dshot_rx_channel.sv
// rtl/dshot_rx_channel.sv - single-channel DShot600 frame receiver with CRC check, speed mapping and failsafe
//
// Optional feature macro: DSHOT_BIDIR_EN
//   defined   : bidirectional (inverted) DShot, line idles high, expected CRC inverted
//   undefined : normal DShot, line idles low, plain CRC
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   dshot_i        raw DShot line, asynchronous to clk
//   speed_o        current target speed 0..249 for the BLCTRL handler
//   speed_valid_o  1-cycle pulse when speed_o was rewritten by a frame
//   telem_req_o    telemetry bit of the last good frame
//   cmd_o          special command 1..47 from the last command frame
//   cmd_valid_o    1-cycle pulse with a new cmd_o
//   crc_err_o      1-cycle pulse: 16 bits received, CRC mismatch
//   frame_err_o    1-cycle pulse: frame aborted (stuck high or gap mid-frame)
//   failsafe_o     high while no good frame has arrived for FAILSAFE_CYC cycles
module dshot_rx_channel #(
    parameter int T_BIT_CYC    = 80,
    parameter int T_THRESH_CYC = 45,
    parameter int GAP_CYC      = 160,
    parameter int FAILSAFE_CYC = 4800000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dshot_i,
    output logic [7:0] speed_o,
    output logic       speed_valid_o,
    output logic       telem_req_o,
    output logic [5:0] cmd_o,
    output logic       cmd_valid_o,
    output logic       crc_err_o,
    output logic       frame_err_o,
    output logic       failsafe_o
);

    localparam int CW = $clog2(GAP_CYC + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] HCNT_ERR = CW'(T_BIT_CYC - 1);
    localparam logic [CW-1:0] HCNT_THR = CW'(T_THRESH_CYC);
    localparam logic [CW-1:0] LCNT_ERR = CW'(GAP_CYC - 1);
    localparam logic [22:0]   FS_MAX   = 23'(FAILSAFE_CYC);

`ifdef DSHOT_BIDIR_EN
    localparam logic IDLE_LVL = 1'b1;
`else
    localparam logic IDLE_LVL = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_CHECK
    } state_t;

    state_t         state;
    logic           sync_q1;
    logic           sync_q2;
    logic           s_d;
    logic [CW-1:0]  hcnt;
    logic [CW-1:0]  lcnt;
    logic [3:0]     bit_cnt;
    logic [15:0]    shreg;
    logic [22:0]    fs_cnt;

    logic           s;
    logic           rise;
    logic           fall;
    logic [11:0]    v;
    logic [10:0]    thr;
    logic [3:0]     crc_exp;
    logic           crc_ok;
    logic           good;
    logic [7:0]     speed_calc;

    // XOR with the idle level makes the active pulse always read as 1,
    // so the rest of the receiver is polarity-agnostic.
    assign s    = sync_q2 ^ IDLE_LVL;
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    assign v          = shreg[15:4];
    assign thr        = shreg[15:5];
    assign crc_exp    = v[3:0] ^ v[7:4] ^ v[11:8] ^ {4{IDLE_LVL}};
    assign crc_ok     = (shreg[3:0] == crc_exp);
    assign good       = (state == ST_CHECK) && crc_ok;
    // thr 48..2047 maps onto 0..249; only called for thr >= 48 so no underflow.
    assign speed_calc = 8'(({1'b0, thr} - 12'd48) >> 3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1       <= IDLE_LVL;
            sync_q2       <= IDLE_LVL;
            s_d           <= 1'b0;
            state         <= ST_IDLE;
            hcnt          <= '0;
            lcnt          <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            fs_cnt        <= '0;
            speed_o       <= '0;
            speed_valid_o <= 1'b0;
            telem_req_o   <= 1'b0;
            cmd_o         <= '0;
            cmd_valid_o   <= 1'b0;
            crc_err_o     <= 1'b0;
            frame_err_o   <= 1'b0;
            failsafe_o    <= 1'b1;
        end else begin
            sync_q1       <= dshot_i;
            sync_q2       <= sync_q1;
            s_d           <= s;
            speed_valid_o <= 1'b0;
            cmd_valid_o   <= 1'b0;
            crc_err_o     <= 1'b0;
            frame_err_o   <= 1'b0;

            // Failsafe timer: any good frame (throttle or command) re-arms it.
            if (good) begin
                fs_cnt     <= '0;
                failsafe_o <= 1'b0;
            end else if (fs_cnt != FS_MAX) begin
                fs_cnt <= fs_cnt + 23'd1;
                if (fs_cnt + 23'd1 == FS_MAX) begin
                    failsafe_o <= 1'b1;
                    speed_o    <= '0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state   <= ST_HIGH;
                        hcnt    <= CNT_ONE;
                        bit_cnt <= '0;
                    end
                end

                ST_HIGH: begin
                    if (fall) begin
                        shreg   <= {shreg[14:0], (hcnt >= HCNT_THR)};
                        bit_cnt <= bit_cnt + 4'd1;
                        lcnt    <= CNT_ONE;
                        // The 16th bit needs no low phase before evaluation.
                        state   <= (bit_cnt == 4'd15) ? ST_CHECK : ST_LOW;
                    end else if (hcnt == HCNT_ERR) begin
                        frame_err_o <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (hcnt != CNT_MAX) begin
                        hcnt <= hcnt + CNT_ONE;
                    end
                end

                ST_LOW: begin
                    if (rise) begin
                        state <= ST_HIGH;
                        hcnt  <= CNT_ONE;
                    end else if (lcnt == LCNT_ERR) begin
                        frame_err_o <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (lcnt != CNT_MAX) begin
                        lcnt <= lcnt + CNT_ONE;
                    end
                end

                ST_CHECK: begin
                    if (crc_ok) begin
                        telem_req_o <= v[0];
                        if (thr == 11'd0) begin
                            speed_o       <= '0;
                            speed_valid_o <= 1'b1;
                        end else if (thr < 11'd48) begin
                            cmd_o       <= thr[5:0];
                            cmd_valid_o <= 1'b1;
                        end else begin
                            speed_o       <= speed_calc;
                            speed_valid_o <= 1'b1;
                        end
                    end else begin
                        crc_err_o <= 1'b1;
                    end
                    // A rising edge seen during evaluation starts the next frame.
                    if (rise) begin
                        state   <= ST_HIGH;
                        hcnt    <= CNT_TWO;
                        bit_cnt <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
